// File: rtl/sram_arb_pkg.sv
// Shared types and widths for the SRAM round-robin arbiter.
package sram_arb_pkg;
  localparam int NPORT  = 4;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;
endpackage

// File: rtl/sram_rr_pick.sv
// Combinational winner selection for four requesters.
// SRAM_ARB_HOST_PRIO_EN: port 0 always wins when requesting; ports 1-3
// rotate among themselves starting at ptr.
module sram_rr_pick (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] winner,
  output logic       valid
);

  logic [1:0] idx;

  // First requester found walking up from ptr, wrapping mod 4.
  always_comb begin
    winner = 2'd0;
    valid  = 1'b0;
    idx    = 2'd0;
`ifdef SRAM_ARB_HOST_PRIO_EN
    if (req[0]) begin
      winner = 2'd0;
      valid  = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        idx = ptr + 2'(i);
        if (!valid && idx != 2'd0 && req[idx]) begin
          winner = idx;
          valid  = 1'b1;
        end
      end
    end
`else
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!valid && req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
`endif
  end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Four-port arbiter in front of an asynchronous 16-bit SRAM.
// One access at a time: IDLE (arbitrate) -> ACCESS (ACCESS_CYC strobe
// cycles) -> DONE (one-cycle oACK) -> IDLE.
// SRAM_ARB_HOST_PRIO_EN: port 0 is a priority host; ptr is left alone
// when it wins so ports 1-3 keep their rotation.
module sram_rr_arbiter
  import sram_arb_pkg::ADDR_W, sram_arb_pkg::DATA_W, sram_arb_pkg::state_t,
         sram_arb_pkg::IDLE, sram_arb_pkg::ACCESS, sram_arb_pkg::DONE;
#(
  parameter int ACCESS_CYC = 2,
  parameter int NPORT      = 4
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic [NPORT-1:0]         iREQ,
  input  logic [NPORT-1:0]         iWE_N,
  input  logic [NPORT*ADDR_W-1:0]  iADDR,
  input  logic [NPORT*DATA_W-1:0]  iWDATA,
  output logic [NPORT-1:0]         oACK,
  output logic [DATA_W-1:0]        oRDATA,
  output logic                     oBUSY,
  inout  wire  [DATA_W-1:0]        SRAM_DQ,
  output logic [ADDR_W-1:0]        SRAM_ADDR,
  output logic                     SRAM_WE_N,
  output logic                     SRAM_OE_N,
  output logic                     SRAM_CE_N,
  output logic                     SRAM_UB_N,
  output logic                     SRAM_LB_N
);

  state_t              state;
  logic [1:0]          ptr;
  logic [1:0]          win;
  logic [1:0]          win_q;
  logic                win_vld;
  logic [3:0]          cnt;
  logic                rd_q;
  logic                dq_oe;
  logic [DATA_W-1:0]   dq_out;

  sram_rr_pick u_pick (
    .req    (iREQ[3:0]),
    .ptr    (ptr),
    .winner (win),
    .valid  (win_vld)
  );

  // Chip always selected, both byte lanes always enabled.
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  // Bus is only driven while a write strobe is active.
  assign SRAM_DQ = dq_oe ? dq_out : 'z;

  // Arbitration FSM; every SRAM-side strobe is a register so the pins are glitch-free.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      cnt       <= 4'd0;
      win_q     <= 2'd0;
      rd_q      <= 1'b0;
      dq_oe     <= 1'b0;
      dq_out    <= '0;
      oACK      <= '0;
      oRDATA    <= '0;
      oBUSY     <= 1'b0;
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            win_q     <= win;
            rd_q      <= iWE_N[win];
            SRAM_ADDR <= iADDR[win*ADDR_W +: ADDR_W];
            dq_out    <= iWDATA[win*DATA_W +: DATA_W];
            dq_oe     <= ~iWE_N[win];
            SRAM_WE_N <= iWE_N[win];
            SRAM_OE_N <= ~iWE_N[win];
            oBUSY     <= 1'b1;
            cnt       <= 4'd0;
            state     <= ACCESS;
`ifdef SRAM_ARB_HOST_PRIO_EN
            if (win != 2'd0) ptr <= win + 2'd1;
`else
            ptr <= win + 2'd1;
`endif
          end
        end
        ACCESS: begin
          if (cnt == 4'(ACCESS_CYC - 1)) begin
            if (rd_q) oRDATA <= SRAM_DQ;
            SRAM_WE_N   <= 1'b1;
            SRAM_OE_N   <= 1'b1;
            dq_oe       <= 1'b0;
            cnt         <= 4'd0;
            oACK        <= '0;
            oACK[win_q] <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          oACK  <= '0;
          oBUSY <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed bench for sram_rr_arbiter (ACCESS_CYC = 2) with a 16-word SRAM model.
module tb_sram_rr_arbiter;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [3:0]  iREQ;
  logic [3:0]  iWE_N;
  logic [71:0] iADDR;
  logic [63:0] iWDATA;
  logic [3:0]  oACK;
  logic [15:0] oRDATA;
  logic        oBUSY;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;

  int tests = 0;
  int fails = 0;

  sram_rr_arbiter #(.ACCESS_CYC(2), .NPORT(4)) dut (
    .iCLK(iCLK), .iRST(iRST), .iREQ(iREQ), .iWE_N(iWE_N), .iADDR(iADDR),
    .iWDATA(iWDATA), .oACK(oACK), .oRDATA(oRDATA), .oBUSY(oBUSY),
    .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N),
    .SRAM_OE_N(SRAM_OE_N), .SRAM_CE_N(SRAM_CE_N), .SRAM_UB_N(SRAM_UB_N),
    .SRAM_LB_N(SRAM_LB_N)
  );

  always #5 iCLK = ~iCLK;

  // Released bus reads as zero.
  pulldown (SRAM_DQ);

  // Tiny SRAM: address bits [3:0] select one of 16 words.
  logic [15:0] mem [16];
  assign SRAM_DQ = (!SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR[3:0]] : 'z;
  always @(posedge iCLK) if (!SRAM_WE_N) mem[SRAM_ADDR[3:0]] <= SRAM_DQ;

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [3:0] exp_ack [5];

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
`ifdef SRAM_ARB_HOST_PRIO_EN
    exp_ack = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    exp_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    iRST   = 1'b1;
    iREQ   = 4'b0000;
    iWE_N  = 4'b1111;
    iADDR  = {18'h00007, 18'h00123, 18'h00123, 18'h00123};
    iWDATA = {16'h5A5A, 16'hBEEF, 16'h1234, 16'h0F0F};

    // Reset state
    tick(); tick();
    iRST = 1'b0;
    chk("rst_ack",   32'(oACK), 32'h0);
    chk("rst_busy",  32'(oBUSY), 32'h0);
    chk("rst_we",    32'(SRAM_WE_N), 32'h1);
    chk("rst_oe",    32'(SRAM_OE_N), 32'h1);
    chk("rst_addr",  32'(SRAM_ADDR), 32'h0);
    chk("rst_rdata", 32'(oRDATA), 32'h0);
    chk("rst_dq",    32'(SRAM_DQ), 32'h0);
    chk("tieoffs",   32'({SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}), 32'h0);

    // Single write from port 2
    iREQ = 4'b0100; iWE_N = 4'b1011;
    tick(); iREQ = 4'b0000;
    chk("wr_c1_we",   32'(SRAM_WE_N), 32'h0);
    chk("wr_c1_oe",   32'(SRAM_OE_N), 32'h1);
    chk("wr_c1_dq",   32'(SRAM_DQ), 32'hBEEF);
    chk("wr_c1_addr", 32'(SRAM_ADDR), 32'h00123);
    chk("wr_c1_busy", 32'(oBUSY), 32'h1);
    chk("wr_c1_ack",  32'(oACK), 32'h0);
    tick();
    chk("wr_c2_we",  32'(SRAM_WE_N), 32'h0);
    chk("wr_c2_dq",  32'(SRAM_DQ), 32'hBEEF);
    chk("wr_c2_ack", 32'(oACK), 32'h0);
    tick();
    chk("wr_ack",       32'(oACK), 32'b0100);
    chk("wr_done_we",   32'(SRAM_WE_N), 32'h1);
    chk("wr_done_dq",   32'(SRAM_DQ), 32'h0);
    chk("wr_done_busy", 32'(oBUSY), 32'h1);
    chk("wr_rdata_hold", 32'(oRDATA), 32'h0);
    tick();
    chk("wr_idle_ack",  32'(oACK), 32'h0);
    chk("wr_idle_busy", 32'(oBUSY), 32'h0);

    // Read-back from port 1
    iREQ = 4'b0010; iWE_N = 4'b1111;
    tick(); iREQ = 4'b0000;
    chk("rd_c1_oe",   32'(SRAM_OE_N), 32'h0);
    chk("rd_c1_we",   32'(SRAM_WE_N), 32'h1);
    chk("rd_c1_dq",   32'(SRAM_DQ), 32'hBEEF);
    chk("rd_c1_addr", 32'(SRAM_ADDR), 32'h00123);
    tick();
    chk("rd_c2_oe", 32'(SRAM_OE_N), 32'h0);
    chk("rd_c2_dq", 32'(SRAM_DQ), 32'hBEEF);
    tick();
    chk("rd_ack",     32'(oACK), 32'b0010);
    chk("rd_rdata",   32'(oRDATA), 32'hBEEF);
    chk("rd_done_oe", 32'(SRAM_OE_N), 32'h1);
    tick();
    chk("rd_idle_ack", 32'(oACK), 32'h0);

    // Contention from reset: all four request, one grant every 4 cycles
    iRST = 1'b1; iREQ = 4'b1111; iWE_N = 4'b1111;
    tick(); iRST = 1'b0;
    tick(); tick();
    chk("cont_pre_ack", 32'(oACK), 32'h0);
    tick();
    chk("cont_ack0", 32'(oACK), 32'(exp_ack[0]));
    for (int n = 1; n < 5; n++) begin
      repeat (4) tick();
      chk($sformatf("cont_ack%0d", n), 32'(oACK), 32'(exp_ack[n]));
    end
    // Port 0 drops: ports 1,2,3 follow in order
    iREQ = 4'b1110;
    repeat (4) tick(); chk("rot_ack1", 32'(oACK), 32'b0010);
    repeat (4) tick(); chk("rot_ack2", 32'(oACK), 32'b0100);
    repeat (4) tick(); chk("rot_ack3", 32'(oACK), 32'b1000);
    iREQ = 4'b0000;
    tick();

    // Reset during the first ACCESS cycle of a port 2 write
    iREQ = 4'b0100; iWE_N = 4'b1011;
    tick();
    chk("abort_c1_we", 32'(SRAM_WE_N), 32'h0);
    iRST = 1'b1; iREQ = 4'b0000;
    tick();
    iRST = 1'b0;
    chk("abort_we",   32'(SRAM_WE_N), 32'h1);
    chk("abort_oe",   32'(SRAM_OE_N), 32'h1);
    chk("abort_dq",   32'(SRAM_DQ), 32'h0);
    chk("abort_busy", 32'(oBUSY), 32'h0);
    chk("abort_ack",  32'(oACK), 32'h0);
    tick();
    chk("abort_noack1", 32'(oACK), 32'h0);
    chk("abort_busy1",  32'(oBUSY), 32'h0);
    tick();
    chk("abort_noack2", 32'(oACK), 32'h0);
    iREQ = 4'b1001; iWE_N = 4'b1111;
    tick(); iREQ = 4'b0000;
    tick(); tick();
    chk("post_rst_ack",   32'(oACK), 32'b0001);
    chk("post_rst_rdata", 32'(oRDATA), 32'hBEEF);
    tick();

    // Port 3 write, request dropped right after the grant
    iREQ = 4'b1000; iWE_N = 4'b0111;
    tick(); iREQ = 4'b0000;
    chk("drop_we",   32'(SRAM_WE_N), 32'h0);
    chk("drop_dq",   32'(SRAM_DQ), 32'h5A5A);
    chk("drop_addr", 32'(SRAM_ADDR), 32'h00007);
    tick(); tick();
    chk("drop_ack",   32'(oACK), 32'b1000);
    chk("drop_rdata", 32'(oRDATA), 32'hBEEF);
    tick();
    chk("drop_ack_once", 32'(oACK), 32'h0);
    chk("drop_idle_busy", 32'(oBUSY), 32'h0);
    tick();
    chk("drop_no_regrant", 32'(oBUSY), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
